serial_adder: RTL and testbench

Bit-serial N-bit adder/subtractor that produces one result bit per clock through a single one-bit full-adder cell and a carry flip-flop. It is the sequential counterpart of the combinational full adder: it trades latency for area. Operands load in parallel on a start strobe, are consumed LSB-first, and the result is presented in parallel with a one-cycle done pulse. Intended for area-constrained datapaths and as the serial core for the later multiplier work.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_if.sv | 31 +++
 rtl/serial_adder_fa_bit.sv | 19 +
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder/subtractor:
//   - FSM state encoding (IDLE, RUN, DONE) as 2-bit constants
//   - bit-counter width helper, clog2(WIDTH) with a floor of one bit
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle for the bit-serial adder.
//   start, sub, a, b, cin : request side, driven by the master
//   busy, done, sum, cout : status/result side, driven by the adder (slave)
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_fa_bit.sv
// -----------------------------------------------------------------------------
// fa_bit
// Purely combinational one-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s        : sum bit
//   co       : carry-out (majority of the three inputs)
// -----------------------------------------------------------------------------
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder/subtractor. Operands load in parallel on start,
// are consumed LSB-first through one full-adder cell and a carry flop, and the
// result is presented in parallel with a one-cycle done pulse.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if slave modport
//          start/sub/a/b/cin sampled in IDLE or DONE only
//          busy high during the WIDTH processing cycles
//          done one-cycle pulse, sum/cout registered and updated on completion
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               s_bit;
  logic               c_bit;

  // Single shared full-adder cell working on the current LSBs.
  fa_bit u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (s_bit),
    .co (c_bit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        // start is deliberately not looked at here.
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_bit;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = {s_bit, res_q[WIDTH-1:1]};
          cout_d  = c_bit;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      // IDLE, DONE and any unused encoding accept a new request.
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert b and force the carry-in.
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed and randomized self-checking bench for serial_adder at WIDTH=8 and
// WIDTH=5. Inputs change on the falling edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(5)) bus5 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  // Present a request on the next falling edge; returns just after E0.
  task automatic start8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic start5(input logic [4:0] a, input logic [4:0] b,
                        input logic cin, input logic sub);
    @(negedge clk);
    bus5.a = a; bus5.b = b; bus5.cin = cin; bus5.sub = sub; bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
  endtask

  // Falling edges until done is seen; -1 when the bound expires.
  task automatic wait_done8(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done5(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus5.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus5.start = 1'b0; bus5.sub = 1'b0; bus5.a = '0; bus5.b = '0; bus5.cin = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0)
      $display("FAIL reset_held: busy=%b done=%b sum=%h cout=%b expected all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0)
      $display("FAIL reset_release: busy=%b done=%b sum=%h cout=%b expected all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    else pass_cnt++;
  endtask

  task automatic test_add();
    int bad;
    int n;
    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    total_cnt++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0)
      $display("FAIL add_busy_e0: busy=%b done=%b expected 1/0", bus8.busy, bus8.done);
    else pass_cnt++;
    bad = 0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0 || bus8.sum !== 8'h00) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL add_run_window: %0d bad cycles expected 0", bad);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus8.done !== 1'b1 || bus8.busy !== 1'b0)
      $display("FAIL add_done_e8: done=%b busy=%b expected 1/0", bus8.done, bus8.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus8.sum !== 8'h96 || bus8.cout !== 1'b0)
      $display("FAIL add_result: sum=%h cout=%b expected 96/0", bus8.sum, bus8.cout);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== 8'h96)
      $display("FAIL add_done_pulse: done=%b busy=%b sum=%h expected 0/0/96",
               bus8.done, bus8.busy, bus8.sum);
    else pass_cnt++;

    start8(8'h5A, 8'h3C, 1'b1, 1'b0);
    wait_done8(n);
    total_cnt++;
    if (n != 8 || bus8.sum !== 8'h97 || bus8.cout !== 1'b0)
      $display("FAIL add_cin: edges=%0d sum=%h cout=%b expected 8/97/0", n, bus8.sum, bus8.cout);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    int n;
    start8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(n);
    total_cnt++;
    if (n != 8 || bus8.sum !== 8'h00 || bus8.cout !== 1'b1)
      $display("FAIL carry_wrap: edges=%0d sum=%h cout=%b expected 8/00/1", n, bus8.sum, bus8.cout);
    else pass_cnt++;
    start8(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done8(n);
    total_cnt++;
    if (n != 8 || bus8.sum !== 8'hFF || bus8.cout !== 1'b1)
      $display("FAIL carry_max: edges=%0d sum=%h cout=%b expected 8/FF/1", n, bus8.sum, bus8.cout);
    else pass_cnt++;
  endtask

  task automatic test_sub();
    int n;
    start8(8'h10, 8'h03, 1'b0, 1'b1);
    wait_done8(n);
    total_cnt++;
    if (n != 8 || bus8.sum !== 8'h0D || bus8.cout !== 1'b1)
      $display("FAIL sub_no_borrow: edges=%0d sum=%h cout=%b expected 8/0D/1", n, bus8.sum, bus8.cout);
    else pass_cnt++;
    // cin toggles every cycle of the run and must not matter.
    start8(8'h03, 8'h10, 1'b1, 1'b1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      bus8.cin = ~bus8.cin;
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        n = i;
        break;
      end
    end
    total_cnt++;
    if (n != 8 || bus8.sum !== 8'hF3 || bus8.cout !== 1'b0)
      $display("FAIL sub_borrow: edges=%0d sum=%h cout=%b expected 8/F3/0", n, bus8.sum, bus8.cout);
    else pass_cnt++;
    bus8.cin = 1'b0;
  endtask

  task automatic test_handshake();
    int n;
    int bad;
    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    // Pulse start across E3 with different operands.
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(n);
    total_cnt++;
    if (n != 5 || bus8.sum !== 8'h96 || bus8.cout !== 1'b0)
      $display("FAIL start_in_run: edges=%0d sum=%h cout=%b expected 5/96/0", n, bus8.sum, bus8.cout);
    else pass_cnt++;

    // Now in DONE: start here must launch the next run with no IDLE cycle.
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    total_cnt++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0 || bus8.sum !== 8'h96)
      $display("FAIL b2b_start: busy=%b done=%b sum=%h expected 1/0/96",
               bus8.busy, bus8.done, bus8.sum);
    else pass_cnt++;
    bad = 0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (bus8.sum !== 8'h96 || bus8.done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL b2b_sum_hold: %0d bad cycles expected 0", bad);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus8.done !== 1'b1 || bus8.sum !== 8'h02 || bus8.cout !== 1'b0)
      $display("FAIL b2b_result: done=%b sum=%h cout=%b expected 1/02/0",
               bus8.done, bus8.sum, bus8.cout);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int n;
    int bad;
    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    // Assert reset between clock edges.
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.cout} !== 11'd0)
      $display("FAIL mid_reset_async: busy=%b done=%b sum=%h cout=%b expected all 0",
               bus8.busy, bus8.done, bus8.sum, bus8.cout);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.sum !== 8'h00) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL mid_reset_abort: %0d bad cycles expected 0", bad);
    else pass_cnt++;
    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done8(n);
    total_cnt++;
    if (n != 8 || bus8.sum !== 8'h96 || bus8.cout !== 1'b0)
      $display("FAIL mid_reset_restart: edges=%0d sum=%h cout=%b expected 8/96/0",
               n, bus8.sum, bus8.cout);
    else pass_cnt++;
  endtask

  task automatic test_random8();
    int n;
    logic [7:0] a, b;
    logic       cin, sub;
    logic [8:0] exp;
    for (int t = 0; t < 200; t++) begin
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      exp = sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b} + {8'd0, cin});
      start8(a, b, cin, sub);
      wait_done8(n);
      total_cnt++;
      if (n != 8 || {bus8.cout, bus8.sum} !== exp)
        $display("FAIL rand8 a=%h b=%h cin=%b sub=%b: edges=%0d got %b_%h expected %b_%h",
                 a, b, cin, sub, n, bus8.cout, bus8.sum, exp[8], exp[7:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random5();
    int n;
    logic [4:0] a, b;
    logic       cin, sub;
    logic [5:0] exp;
    for (int t = 0; t < 200; t++) begin
      a = 5'($urandom); b = 5'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      exp = sub ? ({1'b0, a} + {1'b0, ~b} + 6'd1) : ({1'b0, a} + {1'b0, b} + {5'd0, cin});
      start5(a, b, cin, sub);
      wait_done5(n);
      total_cnt++;
      if (n != 5 || {bus5.cout, bus5.sum} !== exp)
        $display("FAIL rand5 a=%h b=%h cin=%b sub=%b: edges=%0d got %b_%h expected %b_%h",
                 a, b, cin, sub, n, bus5.cout, bus5.sum, exp[5], exp[4:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_handshake();
    test_mid_reset();
    test_random8();
    test_random5();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
